// File: rtl/pfifo_pkg.sv
// pfifo gearbox shared definitions.
// Default geometry and width/index helpers.
package pfifo_pkg;

    localparam int LANE_W_DEF  = 8;
    localparam int MAX_IN_DEF  = 32;
    localparam int MAX_OUT_DEF = 32;
    localparam int DEPTH_DEF   = 192;

    // Ceiling log2, used for elaboration-time widths.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Lane amounts are carried as "count minus one".
    function automatic int amt_ext(input int amt);
        return amt + 1;
    endfunction

    // Modulo add for a non power-of-two ring; off never exceeds depth.
    function automatic int wrap_add(input int base, input int off,
                                    input int depth);
        int s;
        s = base + off;
        if (s >= depth) begin
            s = s - depth;
        end
        return s;
    endfunction

endpackage

// File: rtl/pfifo_lane_mask.sv
// Lane mask: keeps lanes below i_n, zeroes the rest.
// Purely combinational.
module pfifo_lane_mask
    import pfifo_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF,
    parameter int LANES  = MAX_OUT_DEF,
    parameter int N_W    = 9
) (
    input  logic [LANES*LANE_W-1:0] i_data,
    input  logic [N_W-1:0]          i_n,
    output logic [LANES*LANE_W-1:0] o_data
);

    // Pass lane k only when k < i_n.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (N_W'(k) < i_n) begin
                o_data[k*LANE_W +: LANE_W] = i_data[k*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/pfifo_gearbox.sv
// Lane-granular gearbox FIFO over a circular lane buffer.
// Variable-width join and pop, registered pop data.
module pfifo_gearbox
    import pfifo_pkg::*;
#(
    parameter int LANE_W  = LANE_W_DEF,
    parameter int MAX_IN  = MAX_IN_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    localparam int AMT_IN_W  = clog2(MAX_IN),
    localparam int AMT_OUT_W = clog2(MAX_OUT),
    localparam int CNT_W     = clog2(DEPTH + 1)
) (
    input  logic                      i_core_clk,
    input  logic                      i_rx_rst,
    input  logic                      i_flush,
    input  logic [CNT_W-1:0]          i_permit_thresh,
    input  logic                      i_join_en,
    input  logic [AMT_IN_W-1:0]       i_join_amt,
    input  logic [MAX_IN*LANE_W-1:0]  i_join_data,
    output logic                      o_join_permit,
    output logic                      o_join_accept,
    input  logic                      i_pop_ready,
    input  logic [AMT_OUT_W-1:0]      i_pop_amt,
    output logic                      o_pop_valid,
    output logic [MAX_OUT*LANE_W-1:0] o_pop_data,
    output logic [CNT_W-1:0]          o_count,
    output logic [CNT_W-1:0]          o_free,
    output logic                      o_ovf,
    output logic                      o_udf
);

    localparam int LW = CNT_W + 1;

    logic [LANE_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_valid_q, pop_valid_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [MAX_OUT*LANE_W-1:0] pop_data_q, pop_data_d;

    logic [MAX_OUT*LANE_W-1:0] rd_raw;
    logic [MAX_OUT*LANE_W-1:0] rd_masked;
    logic [CNT_W-1:0]          wr_idx [MAX_IN];
    logic [CNT_W-1:0]          rd_idx [MAX_OUT];

    logic [LW-1:0] n_in, n_out, cnt_x, thr_x, depth_x;
    logic          accept, pop_fire, wr_fire, rd_fire;

    // Amount extension and the hard/soft admission checks on pre-cycle count.
    always_comb begin
        n_in     = LW'(amt_ext(int'(i_join_amt)));
        n_out    = LW'(amt_ext(int'(i_pop_amt)));
        cnt_x    = {1'b0, count_q};
        depth_x  = LW'(DEPTH);
        thr_x    = {1'b0, i_permit_thresh};
        if (thr_x > depth_x) begin
            thr_x = depth_x;
        end
        accept   = i_join_en & ((cnt_x + n_in) <= depth_x);
        pop_fire = i_pop_ready & (n_out <= cnt_x);
        wr_fire  = accept & ~i_flush;
        rd_fire  = pop_fire & ~i_flush;
    end

    // Per-lane ring addresses and the raw read window.
    always_comb begin
        rd_raw = '0;
        for (int k = 0; k < MAX_IN; k++) begin
            wr_idx[k] = CNT_W'(wrap_add(int'(wr_ptr_q), k, DEPTH));
        end
        for (int k = 0; k < MAX_OUT; k++) begin
            rd_idx[k] = CNT_W'(wrap_add(int'(rd_ptr_q), k, DEPTH));
            rd_raw[k*LANE_W +: LANE_W] = mem_q[rd_idx[k]];
        end
    end

    pfifo_lane_mask #(
        .LANE_W (LANE_W),
        .LANES  (MAX_OUT),
        .N_W    (LW)
    ) u_mask (
        .i_data (rd_raw),
        .i_n    (n_out),
        .o_data (rd_masked)
    );

    // Lane storage; contents survive reset and flush.
    always_ff @(posedge i_core_clk) begin
        for (int k = 0; k < MAX_IN; k++) begin
            if (wr_fire && (LW'(k) < n_in)) begin
                mem_q[wr_idx[k]] <= i_join_data[k*LANE_W +: LANE_W];
            end
        end
    end

    // Next-state for pointers, count, pop register and sticky flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_d       = ovf_q | (i_join_en & ~accept);
        udf_d       = udf_q | (i_pop_ready & (n_out > cnt_x));
        count_d     = CNT_W'(cnt_x + (wr_fire ? n_in : '0)
                                   - (rd_fire ? n_out : '0));
        if (wr_fire) begin
            wr_ptr_d = CNT_W'(wrap_add(int'(wr_ptr_q), int'(n_in), DEPTH));
        end
        if (rd_fire) begin
            rd_ptr_d    = CNT_W'(wrap_add(int'(rd_ptr_q), int'(n_out), DEPTH));
            pop_data_d  = rd_masked;
            pop_valid_d = 1'b1;
        end
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign o_join_accept = accept;
    assign o_join_permit = (cnt_x + n_in) <= thr_x;
    assign o_pop_valid   = pop_valid_q;
    assign o_pop_data    = pop_data_q;
    assign o_count       = count_q;
    assign o_free        = CNT_W'(DEPTH) - count_q;
    assign o_ovf         = ovf_q;
    assign o_udf         = udf_q;

endmodule
